// File: rtl/data_pipe_nto1_pkt_if.sv
// data_pipe_nto1_pkt_if: wide-in / narrow-out stream bundle for data_pipe_nto1_pkt.
// Write side carries NSIZE x DSIZE words with a lane count; read side carries one lane per beat.
// Optional macro DATA_PIPE_LAST_EN adds the wr_last / rd_last packet markers.
interface data_pipe_nto1_pkt_if #(
  parameter int DSIZE = 4,
  parameter int NSIZE = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(NSIZE + 1);
  localparam int FW = $clog2(DEPTH + 1);

  logic [NSIZE*DSIZE-1:0] wr_data;
  logic [CW-1:0]          wr_cnt;
  logic                   wr_vld;
  logic                   wr_ready;
  logic [DSIZE-1:0]       rd_data;
  logic                   rd_vld;
  logic                   rd_ready;
  logic [FW-1:0]          fill_cnt;
`ifdef DATA_PIPE_LAST_EN
  logic                   wr_last;
  logic                   rd_last;

  modport master (
    output wr_data, wr_cnt, wr_vld, wr_last, rd_ready,
    input  wr_ready, rd_data, rd_vld, rd_last, fill_cnt
  );
  modport slave (
    input  wr_data, wr_cnt, wr_vld, wr_last, rd_ready,
    output wr_ready, rd_data, rd_vld, rd_last, fill_cnt
  );
`else
  modport master (
    output wr_data, wr_cnt, wr_vld, rd_ready,
    input  wr_ready, rd_data, rd_vld, fill_cnt
  );
  modport slave (
    input  wr_data, wr_cnt, wr_vld, rd_ready,
    output wr_ready, rd_data, rd_vld, fill_cnt
  );
`endif
endinterface

// File: rtl/data_pipe_nto1_pkt.sv
// data_pipe_nto1_pkt: N-to-1 width down-converter with a DEPTH-word buffer.
// Each buffered word carries a clamped lane count; only that many lanes are serialised,
// top lane first when MSB_FIRST=1, lane 0 first otherwise.
// Optional macro DATA_PIPE_LAST_EN stores a per-word last flag and drives rd_last
// on the final lane of a flagged word.
module data_pipe_nto1_pkt #(
  parameter int DSIZE     = 4,
  parameter int NSIZE     = 2,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  data_pipe_nto1_pkt_if.slave  bus
);
  localparam int CW = $clog2(NSIZE + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = NSIZE * DSIZE;
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);
  localparam logic [CW-1:0] MAX_CNT  = CW'(NSIZE);

  typedef enum logic {ST_IDLE, ST_SERIAL} state_t;

  logic [WW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt [DEPTH];
`ifdef DATA_PIPE_LAST_EN
  logic          r_last [DEPTH];
`endif
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_lane_idx;
  logic          r_wr_ready;
  state_t        r_state;

  state_t        w_state_nxt;
  logic [FW-1:0] w_fill_nxt;
  logic [CW-1:0] w_lane_nxt;
  logic [CW-1:0] w_head_cnt;
  logic          w_rd_vld;
  logic          w_last_lane;
  logic          w_push;
  logic          w_beat;
  logic          w_pop;

  // A count of 0 or beyond NSIZE means a full word.
  function automatic logic [CW-1:0] clamp_cnt(input logic [CW-1:0] c);
    return ((c == '0) || (c > MAX_CNT)) ? MAX_CNT : c;
  endfunction

  // Map the serial position onto a physical lane according to emission order.
  function automatic logic [DSIZE-1:0] pick_lane(input logic [WW-1:0] word,
                                                 input logic [CW-1:0] idx);
    int l;
    l = (MSB_FIRST != 0) ? (NSIZE - 1 - int'(idx)) : int'(idx);
    return word[l*DSIZE +: DSIZE];
  endfunction

  // Handshake decode: a beat moves one lane, the last lane of the head word pops it.
  always_comb begin
    w_rd_vld    = (r_state == ST_SERIAL);
    w_head_cnt  = r_cnt[r_rd_ptr];
    w_last_lane = (r_lane_idx == (w_head_cnt - CW'(1)));
    w_push      = bus.wr_vld && r_wr_ready;
    w_beat      = w_rd_vld && bus.rd_ready;
    w_pop       = w_beat && w_last_lane;
  end

  // Read FSM next state plus fill/lane bookkeeping; SERIAL exactly while words are buffered.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_lane_nxt  = r_lane_idx;
    if (w_push && !w_pop) begin
      w_fill_nxt = r_fill + FW'(1);
    end else if (!w_push && w_pop) begin
      w_fill_nxt = r_fill - FW'(1);
    end
    if (w_beat) begin
      w_lane_nxt = w_pop ? '0 : (r_lane_idx + CW'(1));
    end
    case (r_state)
      ST_IDLE:   if (w_push) w_state_nxt = ST_SERIAL;
      ST_SERIAL: if (w_fill_nxt == '0) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers; wr_ready is registered from the next fill so it lags a pop by one edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fill     <= '0;
      r_lane_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill     <= w_fill_nxt;
      r_lane_idx <= w_lane_nxt;
      r_wr_ready <= (w_fill_nxt != FULL_CNT);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Word storage: written only on an accepted push, cleared on reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_cnt[i]  <= '0;
`ifdef DATA_PIPE_LAST_EN
        r_last[i] <= 1'b0;
`endif
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr]  <= bus.wr_data;
      r_cnt[r_wr_ptr]  <= clamp_cnt(bus.wr_cnt);
`ifdef DATA_PIPE_LAST_EN
      r_last[r_wr_ptr] <= bus.wr_last;
`endif
    end
  end

  assign bus.wr_ready = r_wr_ready;
  assign bus.rd_vld   = w_rd_vld;
  assign bus.rd_data  = w_rd_vld ? pick_lane(r_mem[r_rd_ptr], r_lane_idx) : '0;
  assign bus.fill_cnt = r_fill;
`ifdef DATA_PIPE_LAST_EN
  assign bus.rd_last  = w_rd_vld && r_last[r_rd_ptr] && w_last_lane;
`endif

endmodule

// File: tb/tb_data_pipe_nto1_pkt.sv
// tb_data_pipe_nto1_pkt: directed bench for data_pipe_nto1_pkt (DSIZE=4, NSIZE=2, DEPTH=4).
// An MSB-first instance is the main target; an LSB-first twin shares its inputs for the order test.
module tb_data_pipe_nto1_pkt;
  localparam int DSIZE = 4;
  localparam int NSIZE = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  logic [4:0] exp_q[$];

  data_pipe_nto1_pkt_if #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH)) u_if ();
  data_pipe_nto1_pkt_if #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH)) u_if_lsb ();

  data_pipe_nto1_pkt #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH), .MSB_FIRST(1)) u_dut (
    .clock(clk), .rst(rst), .bus(u_if.slave)
  );
  data_pipe_nto1_pkt #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH), .MSB_FIRST(0)) u_dut_lsb (
    .clock(clk), .rst(rst), .bus(u_if_lsb.slave)
  );

  assign u_if_lsb.wr_data  = u_if.wr_data;
  assign u_if_lsb.wr_cnt   = u_if.wr_cnt;
  assign u_if_lsb.wr_vld   = u_if.wr_vld;
  assign u_if_lsb.rd_ready = u_if.rd_ready;
`ifdef DATA_PIPE_LAST_EN
  assign u_if_lsb.wr_last  = u_if.wr_last;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_last();
`ifdef DATA_PIPE_LAST_EN
    return u_if.rd_last;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic in_last();
`ifdef DATA_PIPE_LAST_EN
    return u_if.wr_last;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_last(input logic v);
`ifdef DATA_PIPE_LAST_EN
    u_if.wr_last = v;
`else
    if (v) begin end
`endif
  endtask

  // Expected beats of one accepted word, MSB lane first; last marker on its final lane.
  task automatic push_expect(input logic [7:0] word, input logic [1:0] cnt, input logic last);
    int c;
    c = ((cnt == 2'd0) || (cnt > 2'd2)) ? 2 : int'(cnt);
    for (int k = 0; k < c; k++) begin
      logic [3:0] nib;
      nib = (k == 0) ? word[7:4] : word[3:0];
      exp_q.push_back({last && (k == c - 1), nib});
    end
  endtask

  // One clock: score handshakes that occur at the coming edge, then check stall hold.
  task automatic cyc();
    logic wf, rf, st;
    logic [3:0] pd;
    logic [4:0] ob;
    wf = u_if.wr_vld && u_if.wr_ready;
    rf = u_if.rd_vld && u_if.rd_ready;
    st = u_if.rd_vld && !u_if.rd_ready;
    pd = u_if.rd_data;
    ob = {obs_last(), u_if.rd_data};
    if (wf) push_expect(u_if.wr_data, u_if.wr_cnt, in_last());
    if (rf) begin
      beats++;
      chk("beat_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("beat", 32'(ob), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    if (st) begin
      chk("stall_data", 32'(u_if.rd_data), 32'(pd));
      chk("stall_vld", 32'(u_if.rd_vld), 1);
    end
  endtask

  task automatic stream(input bit bp, input string tag);
    int wi, n, b0;
    logic fire;
    wi = 0; n = 0; b0 = beats;
    u_if.wr_cnt = 2'd2;
    set_last(1'b0);
    while (n < 1000 && !(wi == 50 && beats - b0 == 100)) begin
      u_if.wr_vld   = (wi < 50);
      u_if.wr_data  = 8'(32'hFF - wi);
      u_if.rd_ready = (n >= 10) && (!bp || (n % 2 == 0));
      fire = u_if.wr_vld && u_if.wr_ready;
      cyc();
      if (fire) wi++;
      n++;
    end
    u_if.wr_vld   = 1'b0;
    u_if.rd_ready = 1'b1;
    chk({tag, "_words"}, 32'(wi), 50);
    chk({tag, "_beats"}, 32'(beats - b0), 100);
    chk({tag, "_rd_vld_end"}, 32'(u_if.rd_vld), 0);
    repeat (4) cyc();
    chk({tag, "_no_extra"}, 32'(beats - b0), 100);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int acc, b0, nb;
    logic fire;
    logic [3:0] got[8];

    rst = 1'b1;
    u_if.wr_data = '0; u_if.wr_cnt = '0; u_if.wr_vld = 1'b0; u_if.rd_ready = 1'b0;
    set_last(1'b0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rd_vld", 32'(u_if.rd_vld), 0);
    chk("rst_rd_data", 32'(u_if.rd_data), 0);
    chk("rst_wr_ready", 32'(u_if.wr_ready), 0);
    chk("rst_fill", 32'(u_if.fill_cnt), 0);
`ifdef DATA_PIPE_LAST_EN
    chk("rst_rd_last", 32'(u_if.rd_last), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("wr_ready_after_rst", 32'(u_if.wr_ready), 1);

    // Test 1: lane order for 8'hA5
    u_if.wr_data = 8'hA5; u_if.wr_cnt = 2'd2; u_if.wr_vld = 1'b1; u_if.rd_ready = 1'b1;
    cyc();
    u_if.wr_vld = 1'b0;
    chk("t1_rd_vld", 32'(u_if.rd_vld), 1);
    chk("t1_fill", 32'(u_if.fill_cnt), 1);
    chk("t1_msb_first0", 32'(u_if.rd_data), 32'hA);
    chk("t1_lsb_first0", 32'(u_if_lsb.rd_data), 32'h5);
    cyc();
    chk("t1_msb_first1", 32'(u_if.rd_data), 32'h5);
    chk("t1_lsb_first1", 32'(u_if_lsb.rd_data), 32'hA);
    cyc();
    chk("t1_empty_vld", 32'(u_if.rd_vld), 0);
    chk("t1_empty_data", 32'(u_if.rd_data), 0);

    // Test 3: fill to capacity with the reader stalled
    u_if.rd_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      u_if.wr_vld  = 1'b1;
      u_if.wr_data = 8'(32'h10 + acc);
      fire = u_if.wr_vld && u_if.wr_ready;
      cyc();
      if (fire) begin
        acc++;
        if (acc == 4) chk("t3_ready_after_4th", 32'(u_if.wr_ready), 0);
      end
    end
    u_if.wr_vld = 1'b0;
    chk("t3_accepted", 32'(acc), 4);
    chk("t3_wr_ready", 32'(u_if.wr_ready), 0);
    chk("t3_fill", 32'(u_if.fill_cnt), 4);
    chk("t3_head", 32'(u_if.rd_data), 32'h1);
    u_if.rd_ready = 1'b1;
    cyc();
    chk("t3_ready_mid_word", 32'(u_if.wr_ready), 0);
    chk("t3_second_lane", 32'(u_if.rd_data), 32'h0);
    cyc();
    u_if.rd_ready = 1'b0;
    chk("t3_ready_after_pop", 32'(u_if.wr_ready), 1);
    chk("t3_fill_after_pop", 32'(u_if.fill_cnt), 3);
    chk("t3_next_head", 32'(u_if.rd_data), 32'h1);
    u_if.rd_ready = 1'b1;
    repeat (8) cyc();
    chk("t3_drained", 32'(u_if.fill_cnt), 0);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // Test 4: partial words with counts 2, 1, 0
    u_if.rd_ready = 1'b0;
    u_if.wr_vld = 1'b1;
    u_if.wr_data = 8'h5A; u_if.wr_cnt = 2'd2; set_last(1'b0); cyc();
    u_if.wr_data = 8'h3C; u_if.wr_cnt = 2'd1; set_last(1'b1); cyc();
    u_if.wr_data = 8'h96; u_if.wr_cnt = 2'd0; set_last(1'b0); cyc();
    u_if.wr_vld = 1'b0;
    chk("t4_fill", 32'(u_if.fill_cnt), 3);
    b0 = beats; nb = 0;
    u_if.rd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (u_if.rd_vld && nb < 8) begin
        got[nb] = u_if.rd_data;
        nb++;
      end
      cyc();
    end
    chk("t4_beats", 32'(beats - b0), 5);
    chk("t4_rd_vld_end", 32'(u_if.rd_vld), 0);
    chk("t4_b0", 32'(got[0]), 32'h5);
    chk("t4_b1", 32'(got[1]), 32'hA);
    chk("t4_b2", 32'(got[2]), 32'h3);
    chk("t4_b3", 32'(got[3]), 32'h9);
    chk("t4_b4", 32'(got[4]), 32'h6);

    // Test 2: 50-word stream, reader starts late
    stream(1'b0, "t2");

    // Test 5: same stream with alternating backpressure
    stream(1'b1, "t5");

    // Test 6: reset with three words buffered
    u_if.rd_ready = 1'b0;
    u_if.wr_cnt = 2'd2;
    u_if.wr_vld = 1'b1;
    u_if.wr_data = 8'h71; cyc();
    u_if.wr_data = 8'h72; cyc();
    u_if.wr_data = 8'h73; cyc();
    u_if.wr_vld = 1'b0;
    chk("t6_fill_before", 32'(u_if.fill_cnt), 3);
    chk("t6_vld_before", 32'(u_if.rd_vld), 1);
    rst = 1'b1;
    #1;
    chk("t6_async_vld", 32'(u_if.rd_vld), 0);
    chk("t6_async_fill", 32'(u_if.fill_cnt), 0);
    chk("t6_async_data", 32'(u_if.rd_data), 0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("t6_ready_in_rst", 32'(u_if.wr_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_ready_after_rst", 32'(u_if.wr_ready), 1);
    b0 = beats;
    u_if.rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t6_no_stale_vld", 32'(u_if.rd_vld), 0);
      cyc();
    end
    chk("t6_no_stale_beats", 32'(beats - b0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
